// File: rtl/tl_pkg.sv
// Shared definitions for the emergency preemption sequencer.
//
// Lamp vectors are 8 bits wide. Bit 7 is the MSB and holds the high bit of
// direction 0, so direction k occupies bits [7-2k : 6-2k].
//
// Lamp encoding: RED=2'b00, YELLOW=2'b01, GREEN=2'b10. The code 2'b11 is
// invalid and is shown as RED.
package tl_pkg;

  localparam int NUM_DIRS = 4;

  localparam logic [1:0] LT_RED    = 2'b00;
  localparam logic [1:0] LT_YELLOW = 2'b01;
  localparam logic [1:0] LT_GREEN  = 2'b10;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    YELLOW      = 3'd1,
    ALLRED      = 3'd2,
    EMERG_GREEN = 3'd3,
    EXIT_ALLRED = 3'd4
  } tl_state_t;

  // A direction requests when either of its two override lanes is high.
  function automatic logic [NUM_DIRS-1:0] dir_req(input logic [7:0] lane);
    logic [NUM_DIRS-1:0] r;
    r = '0;
    for (int k = 0; k < NUM_DIRS; k++) begin
      r[k] = |lane[(NUM_DIRS-1-k)*2 +: 2];
    end
    return r;
  endfunction

  // Lowest-index requesting direction wins; 0 when nothing requests.
  function automatic logic [1:0] pick_lowest(input logic [NUM_DIRS-1:0] req);
    logic [1:0] p;
    p = '0;
    for (int k = NUM_DIRS - 1; k >= 0; k--) begin
      if (req[k]) p = 2'(k);
    end
    return p;
  endfunction

  // Replace the invalid 2'b11 code with RED in every direction.
  function automatic logic [7:0] sanitise(input logic [7:0] v);
    logic [7:0] o;
    o = v;
    for (int k = 0; k < NUM_DIRS; k++) begin
      if (v[(NUM_DIRS-1-k)*2 +: 2] == 2'b11) o[(NUM_DIRS-1-k)*2 +: 2] = LT_RED;
    end
    return o;
  endfunction

  // Only direction dir GREEN, everyone else RED.
  function automatic logic [7:0] solo_green(input logic [1:0] dir);
    logic [7:0] o;
    o = '0;
    for (int k = 0; k < NUM_DIRS; k++) begin
      if (2'(k) == dir) o[(NUM_DIRS-1-k)*2 +: 2] = LT_GREEN;
    end
    return o;
  endfunction

  // Clearing pattern: every GREEN direction other than keep turns YELLOW,
  // everything else shows RED.
  function automatic logic [7:0] clear_pattern(input logic [7:0] lights,
                                               input logic [1:0] keep);
    logic [7:0] o;
    o = '0;
    for (int k = 0; k < NUM_DIRS; k++) begin
      if (2'(k) != keep && lights[(NUM_DIRS-1-k)*2 +: 2] == LT_GREEN)
        o[(NUM_DIRS-1-k)*2 +: 2] = LT_YELLOW;
    end
    return o;
  endfunction

endpackage

// File: rtl/preempt_timer.sv
// Loadable down-counter used to time each sequencer state.
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   load        reload count with load_val (asserted on every state entry)
//   load_val    duration of the state being entered, in cycles
//   done        high while the count sits at 1, i.e. in the last cycle of
//               the state; the count holds at 1 until the next load
module preempt_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count > W'(1)) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == W'(1));

endmodule

// File: rtl/emergency_preempt_sequencer.sv
// Emergency preemption sequencer between the normal phase controller and
// the lamp drivers. In IDLE it registers the (sanitised) normal lights; on an
// emergency request it clears conflicting greens through yellow and all-red,
// holds the requesting direction green for at least MIN_GREEN_CYCLES, then
// hands back through an all-red interval.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   emergencyLane  per-lane override, direction k requests on bit 7-2k or 6-2k
//   normalLights   normal controller lamps, 2 bits per direction
//   lightsOut      registered lamp states, same packing
//   normalHold     high in every state other than IDLE
//   preemptActive  high only in EMERG_GREEN
//   servedDir      direction being served, 0 in IDLE
//   fsm_state      current state (tl_state_t encoding) for observation
//
// Handshake: there is none; emergencyLane is a level request sampled every
// cycle, and each output is a register updated on every clock edge.
module emergency_preempt_sequencer
  import tl_pkg::*;
#(
  parameter int YELLOW_CYCLES      = 3,
  parameter int ALLRED_CYCLES      = 2,
  parameter int MIN_GREEN_CYCLES   = 5,
  parameter int EXIT_ALLRED_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] emergencyLane,
  input  logic [7:0] normalLights,
  output logic [7:0] lightsOut,
  output logic       normalHold,
  output logic       preemptActive,
  output logic [1:0] servedDir,
  output logic [2:0] fsm_state
);

  localparam int MAX_AB  = (YELLOW_CYCLES > ALLRED_CYCLES) ? YELLOW_CYCLES : ALLRED_CYCLES;
  localparam int MAX_CD  = (MIN_GREEN_CYCLES > EXIT_ALLRED_CYCLES) ? MIN_GREEN_CYCLES
                                                                   : EXIT_ALLRED_CYCLES;
  localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW      = $clog2(MAX_CYC + 1);

  tl_state_t               state;
  tl_state_t               nxt_state;
  logic [NUM_DIRS-1:0]     req;
  logic [NUM_DIRS-1:0]     other_req;
  logic [1:0]              pick;
  logic [1:0]              reroute_dir;
  logic                    tmr_load;
  logic [CW-1:0]           tmr_val;
  logic                    tmr_done;

  always_comb begin
    req         = dir_req(emergencyLane);
    pick        = pick_lowest(req);
    other_req   = req & ~(4'b0001 << servedDir);
    reroute_dir = pick_lowest(other_req);
    nxt_state   = state;
    case (state)
      IDLE: begin
        // Skip the clearing phases when the requester is already the sole green.
        if (|req) nxt_state = (lightsOut == solo_green(pick)) ? EMERG_GREEN : YELLOW;
      end
      YELLOW:      if (tmr_done) nxt_state = ALLRED;
      ALLRED:      if (tmr_done) nxt_state = EMERG_GREEN;
      EMERG_GREEN: begin
        if (tmr_done && !req[servedDir]) nxt_state = (|other_req) ? YELLOW : EXIT_ALLRED;
      end
      EXIT_ALLRED: if (tmr_done) nxt_state = IDLE;
      default:     nxt_state = IDLE;
    endcase

    // Every state change is a state entry, and every entry reloads the timer.
    tmr_load = (nxt_state != state);
    case (nxt_state)
      YELLOW:      tmr_val = CW'(YELLOW_CYCLES);
      ALLRED:      tmr_val = CW'(ALLRED_CYCLES);
      EMERG_GREEN: tmr_val = CW'(MIN_GREEN_CYCLES);
      EXIT_ALLRED: tmr_val = CW'(EXIT_ALLRED_CYCLES);
      default:     tmr_val = '0;
    endcase
  end

  preempt_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      lightsOut     <= '0;
      normalHold    <= 1'b0;
      preemptActive <= 1'b0;
      servedDir     <= '0;
    end else begin
      state         <= nxt_state;
      normalHold    <= (nxt_state != IDLE);
      preemptActive <= (nxt_state == EMERG_GREEN);
      case (state)
        IDLE: begin
          if (nxt_state == EMERG_GREEN) begin
            servedDir <= pick;
            lightsOut <= solo_green(pick);
          end else if (nxt_state == YELLOW) begin
            servedDir <= pick;
            lightsOut <= clear_pattern(lightsOut, pick);
          end else begin
            lightsOut <= sanitise(normalLights);
          end
        end
        YELLOW: if (nxt_state == ALLRED) lightsOut <= '0;
        ALLRED: if (nxt_state == EMERG_GREEN) lightsOut <= solo_green(servedDir);
        EMERG_GREEN: begin
          if (nxt_state == YELLOW) begin
            // The outgoing direction is the only green, so it alone turns yellow.
            servedDir <= reroute_dir;
            lightsOut <= clear_pattern(lightsOut, reroute_dir);
          end else if (nxt_state == EXIT_ALLRED) begin
            lightsOut <= '0;
          end
        end
        EXIT_ALLRED: begin
          if (nxt_state == IDLE) begin
            servedDir <= '0;
            lightsOut <= sanitise(normalLights);
          end
        end
        default: lightsOut <= '0;
      endcase
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_emergency_preempt_sequencer.sv
// Bench for emergency_preempt_sequencer. A behavioural model turns each
// cycle's inputs into the expected output frame
// {lightsOut, normalHold, preemptActive, servedDir}; a monitor compares one
// frame per cycle on the falling edge.
module tb_emergency_preempt_sequencer;

  localparam int YC = 3;
  localparam int AC = 2;
  localparam int MG = 5;
  localparam int XC = 2;
  localparam int W  = 12;

  localparam int M_PASS  = 0;
  localparam int M_PLAN  = 1;
  localparam int M_GREEN = 2;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] emergency_lane = 8'h00;
  logic [7:0] normal_lights = 8'hA0;
  logic [7:0] lights_out;
  logic       normal_hold;
  logic       preempt_active;
  logic [1:0] served_dir;
  logic [2:0] fsm_state;

  always #5 clk = ~clk;

  emergency_preempt_sequencer #(
    .YELLOW_CYCLES      (YC),
    .ALLRED_CYCLES      (AC),
    .MIN_GREEN_CYCLES   (MG),
    .EXIT_ALLRED_CYCLES (XC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .emergencyLane (emergency_lane),
    .normalLights  (normal_lights),
    .lightsOut     (lights_out),
    .normalHold    (normal_hold),
    .preemptActive (preempt_active),
    .servedDir     (served_dir),
    .fsm_state     (fsm_state)
  );

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  // ---------------- reference model ----------------
  // Direction k lamp lives in bits {7-2k, 6-2k}.
  function automatic logic [1:0] lamp(input logic [7:0] v, input int k);
    return {v[7-2*k], v[6-2*k]};
  endfunction

  function automatic logic [7:0] put(input logic [7:0] v, input int k, input logic [1:0] l);
    logic [7:0] o;
    o = v;
    o[7-2*k] = l[1];
    o[6-2*k] = l[0];
    return o;
  endfunction

  function automatic logic [3:0] reqs(input logic [7:0] e);
    logic [3:0] r;
    for (int k = 0; k < 4; k++) r[k] = e[7-2*k] | e[6-2*k];
    return r;
  endfunction

  function automatic int lowest(input logic [3:0] r);
    for (int k = 0; k < 4; k++) if (r[k]) return k;
    return 0;
  endfunction

  function automatic logic [7:0] clean(input logic [7:0] v);
    logic [7:0] o;
    o = v;
    for (int k = 0; k < 4; k++) if (lamp(v, k) == 2'b11) o = put(o, k, 2'b00);
    return o;
  endfunction

  function automatic logic [7:0] only_green(input int k);
    return put(8'h00, k, 2'b10);
  endfunction

  function automatic logic [7:0] clear_pat(input logic [7:0] v, input int keep);
    logic [7:0] o;
    o = 8'h00;
    for (int k = 0; k < 4; k++) if (k != keep && lamp(v, k) == 2'b10) o = put(o, k, 2'b01);
    return o;
  endfunction

  function automatic logic [W-1:0] mk(input logic [7:0] l, input logic h, input logic a, input int s);
    return {l, h, a, 2'(s)};
  endfunction

  // Model state: a queue of fixed upcoming frames (clearing / exit phases),
  // what follows the queue, and the age of an ongoing emergency green.
  int           m_mode;
  logic [7:0]   m_lights;
  int           g_dir;
  int           g_age;
  bit           after_green;
  logic [W-1:0] plan_q[$];

  task automatic model_reset();
    m_mode = M_PASS;
    m_lights = 8'h00;
    g_dir = 0;
    g_age = 0;
    after_green = 0;
    plan_q.delete();
  endtask

  task automatic plan_clearing(input logic [7:0] pat, input int d);
    repeat (YC) plan_q.push_back(mk(pat, 1'b1, 1'b0, d));
    repeat (AC) plan_q.push_back(mk(8'h00, 1'b1, 1'b0, d));
    after_green = 1;
    g_dir = d;
  endtask

  task automatic model_step(input logic [7:0] nl, input logic [7:0] el, output logic [W-1:0] f);
    logic [3:0] r;
    int n;
    r = reqs(el);
    if (m_mode == M_PASS) begin
      if (r != 0) begin
        n = lowest(r);
        if (m_lights == only_green(n)) begin
          m_mode = M_GREEN;
          g_dir = n;
          g_age = 1;
          f = mk(only_green(n), 1'b1, 1'b1, n);
        end else begin
          plan_clearing(clear_pat(m_lights, n), n);
          m_mode = M_PLAN;
          f = plan_q.pop_front();
        end
      end else begin
        f = mk(clean(nl), 1'b0, 1'b0, 0);
      end
    end else if (m_mode == M_PLAN) begin
      if (plan_q.size() != 0) begin
        f = plan_q.pop_front();
      end else if (after_green) begin
        m_mode = M_GREEN;
        g_age = 1;
        f = mk(only_green(g_dir), 1'b1, 1'b1, g_dir);
      end else begin
        m_mode = M_PASS;
        f = mk(clean(nl), 1'b0, 1'b0, 0);
      end
    end else begin
      if (g_age >= MG && !r[g_dir]) begin
        if (r != 0) begin
          plan_clearing(clear_pat(m_lights, lowest(r)), lowest(r));
        end else begin
          repeat (XC) plan_q.push_back(mk(8'h00, 1'b1, 1'b0, g_dir));
          after_green = 0;
        end
        m_mode = M_PLAN;
        f = plan_q.pop_front();
      end else begin
        g_age++;
        f = mk(only_green(g_dir), 1'b1, 1'b1, g_dir);
      end
    end
    m_lights = f[11:4];
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after a rising edge; the frame expected after
  // the next edge is queued at that edge.
  task automatic step(input logic [7:0] nl, input logic [7:0] el);
    logic [W-1:0] f;
    normal_lights = nl;
    emergency_lane = el;
    model_step(nl, el, f);
    @(posedge clk);
    exp_q.push_back(f);
    #1;
  endtask

  task automatic drive(input logic [7:0] nl, input logic [7:0] el, input int n);
    repeat (n) step(nl, el);
  endtask

  task automatic do_reset(input int n);
    if (rst_n) begin
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      // Reset must act without waiting for a clock edge.
      checks++;
      if ({lights_out, normal_hold, preempt_active, served_dir} !== 12'h000 || fsm_state !== 3'd0) begin
        errors++;
        $display("FAIL async_reset lights=%h hold=%b active=%b served=%0d state=%0d want all zero",
                 lights_out, normal_hold, preempt_active, served_dir, fsm_state);
      end
    end
    model_reset();
    repeat (n) begin
      @(posedge clk);
      exp_q.push_back(12'h000);
      #1;
    end
    rst_n = 1'b1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] got;
    logic [W-1:0] exp;
    got = {lights_out, normal_hold, preempt_active, served_dir};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL frame_underflow t=%0t got lights=%h with no expected frame", $time, lights_out);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        errors++;
        $display("FAIL frame t=%0t got lights=%h hold=%b active=%b served=%0d exp lights=%h hold=%b active=%b served=%0d",
                 $time, got[11:4], got[3], got[2], got[1:0], exp[11:4], exp[3], exp[2], exp[1:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] nl_cur;
    logic [7:0] el_cur;
    int hold_left;

    model_reset();
    do_reset(3);

    // Pass-through after reset, then invalid codes shown as RED.
    drive(8'hA0, 8'h00, 3);
    drive(8'hFF, 8'h00, 3);

    // dir0 green, one-cycle dir1 request: full clearing sequence.
    drive(8'h80, 8'h00, 3);
    drive(8'h80, 8'h20, 1);
    drive(8'h80, 8'h00, 16);

    // dir0 already the sole green, request held 10 cycles: no yellow.
    drive(8'h80, 8'h40, 10);
    drive(8'h80, 8'h00, 10);

    // dir2 and dir3 together; dir2 wins, then dir3 is served after it drops.
    drive(8'h80, 8'h0F, 12);
    drive(8'h80, 8'h03, 16);
    drive(8'h80, 8'h00, 10);

    // Reset during the second all-red cycle.
    drive(8'h80, 8'h00, 3);
    drive(8'h80, 8'h20, 1);
    drive(8'h80, 8'h00, 4);
    do_reset(2);
    drive(8'h80, 8'h00, 3);

    // Randomised traffic.
    nl_cur = 8'h80;
    el_cur = 8'h00;
    hold_left = 0;
    for (int c = 0; c < 800; c++) begin
      if (c == 400) do_reset(2);
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 5))
          0: nl_cur = 8'h80;
          1: nl_cur = 8'h20;
          2: nl_cur = 8'h08;
          3: nl_cur = 8'h02;
          4: nl_cur = 8'($urandom);
          default: nl_cur = 8'h00;
        endcase
      end
      if (hold_left > 0) begin
        hold_left--;
      end else if ($urandom_range(0, 9) == 0) begin
        el_cur = 8'($urandom_range(1, 255));
        hold_left = $urandom_range(0, 14);
      end else begin
        el_cur = 8'h00;
      end
      step(nl_cur, el_cur);
    end
    drive(nl_cur, 8'h00, 20);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_frames got %0d frames pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
